// File: rtl/p4_result_packer_if.sv
// Result-in / packed-word-out bus of the result packer: upstream result handshake,
// downstream word handshake and status.
interface p4_result_packer_if #(
    parameter int W     = 3,
    parameter int N     = 4,
    parameter int CNT_W = 8
) ();
    logic             C0;
    logic             C1;
    logic             C2;
    logic             In_valid;
    logic             In_ready;
    logic [W*N-1:0]   Out_data;
    logic             Out_valid;
    logic             Out_ready;
    logic [CNT_W-1:0] Word_cnt;
    logic             Overflow;

    modport master (
        output C0, C1, C2, In_valid, Out_ready,
        input  In_ready, Out_data, Out_valid, Word_cnt, Overflow
    );

    modport slave (
        input  C0, C1, C2, In_valid, Out_ready,
        output In_ready, Out_data, Out_valid, Word_cnt, Overflow
    );
endinterface

// File: rtl/p4_result_packer.sv
// Packs N consecutive W-bit results into one word behind a valid/ready output,
// with a completed-word counter and a sticky overflow flag for dropped results.
module p4_result_packer #(
    parameter int W     = 3,
    parameter int N     = 4,
    parameter int CNT_W = 8
) (
    input logic                Clk,
    input logic                Rst_n,
    p4_result_packer_if.slave  bus
);
    localparam int IDX_W = $clog2(N);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        STALL   = 1'b1
    } state_t;

    state_t           state_r, state_next_s;
    logic [IDX_W-1:0] idx_r, idx_next_s;
    logic [W*N-1:0]   coll_r, coll_next_s;
    logic [W*N-1:0]   out_data_r, out_data_next_s;
    logic             out_valid_r, out_valid_next_s;
    logic [CNT_W-1:0] cnt_r, cnt_next_s;
    logic             ovf_r, ovf_next_s;

    logic [W-1:0]     result_s;
    logic             in_ready_s;
    logic             out_hs_s;
    logic             out_free_s;
    logic             last_s;

    assign result_s = {bus.C2, bus.C1, bus.C0};

    // Next-state, slot write, output-register load and status update
    always_comb begin
        state_next_s     = state_r;
        idx_next_s       = idx_r;
        coll_next_s      = coll_r;
        out_data_next_s  = out_data_r;
        out_valid_next_s = out_valid_r;
        cnt_next_s       = cnt_r;
        ovf_next_s       = ovf_r;
        in_ready_s       = 1'b0;
        out_hs_s         = out_valid_r && bus.Out_ready;
        out_free_s       = !out_valid_r || bus.Out_ready;
        last_s           = (idx_r == IDX_W'(N - 1));

        // A completed handshake empties the output unless a word reloads it below
        if (out_hs_s) begin
            cnt_next_s       = cnt_r + CNT_W'(1);
            out_valid_next_s = 1'b0;
        end else begin
            cnt_next_s       = cnt_r;
        end

        case (state_r)
            COLLECT: begin
                in_ready_s = 1'b1;
                if (bus.In_valid) begin
                    coll_next_s[W*idx_r +: W] = result_s;
                    if (!last_s) begin
                        idx_next_s = idx_r + IDX_W'(1);
                    end else if (out_free_s) begin
                        out_data_next_s  = coll_next_s;
                        out_valid_next_s = 1'b1;
                        idx_next_s       = {IDX_W{1'b0}};
                    end else begin
                        state_next_s = STALL;
                    end
                end else begin
                    idx_next_s = idx_r;
                end
            end
            STALL: begin
                in_ready_s = 1'b0;
                if (bus.In_valid) begin
                    ovf_next_s = 1'b1;
                end else begin
                    ovf_next_s = ovf_r;
                end
                // The collector already holds the complete word; move it on release
                if (out_hs_s) begin
                    out_data_next_s  = coll_r;
                    out_valid_next_s = 1'b1;
                    idx_next_s       = {IDX_W{1'b0}};
                    state_next_s     = COLLECT;
                end else begin
                    state_next_s = STALL;
                end
            end
            default: begin
                state_next_s = COLLECT;
                idx_next_s   = {IDX_W{1'b0}};
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_r     <= COLLECT;
            idx_r       <= {IDX_W{1'b0}};
            coll_r      <= {(W*N){1'b0}};
            out_data_r  <= {(W*N){1'b0}};
            out_valid_r <= 1'b0;
            cnt_r       <= {CNT_W{1'b0}};
            ovf_r       <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            idx_r       <= idx_next_s;
            coll_r      <= coll_next_s;
            out_data_r  <= out_data_next_s;
            out_valid_r <= out_valid_next_s;
            cnt_r       <= cnt_next_s;
            ovf_r       <= ovf_next_s;
        end
    end

    assign bus.In_ready  = in_ready_s;
    assign bus.Out_data  = out_data_r;
    assign bus.Out_valid = out_valid_r;
    assign bus.Word_cnt  = cnt_r;
    assign bus.Overflow  = ovf_r;
endmodule

// File: tb/tb_p4_result_packer.sv
// Bench for p4_result_packer: fixed vector table, directed corner sequences and a
// random run, all checked against a queue-based model of accepted results and words.
module tb_p4_result_packer;
    logic Clk = 1'b0;
    logic Rst_n;
    always #5 Clk = ~Clk;

    p4_result_packer_if #(.W(3), .N(4), .CNT_W(8)) bus1 ();
    p4_result_packer_if #(.W(3), .N(4), .CNT_W(2)) bus2 ();

    assign bus2.C0        = bus1.C0;
    assign bus2.C1        = bus1.C1;
    assign bus2.C2        = bus1.C2;
    assign bus2.In_valid  = bus1.In_valid;
    assign bus2.Out_ready = bus1.Out_ready;

    p4_result_packer #(.W(3), .N(4), .CNT_W(8)) dut1 (.Clk(Clk), .Rst_n(Rst_n), .bus(bus1));
    p4_result_packer #(.W(3), .N(4), .CNT_W(2)) dut2 (.Clk(Clk), .Rst_n(Rst_n), .bus(bus2));

    int n_vec = 0;
    int n_err = 0;

    // Model: words waiting for output (head = Out_data) and results of the word in progress
    logic [11:0] words_q[$];
    logic [2:0]  cur_q[$];
    int          m_cnt = 0;
    bit          m_ovf = 1'b0;

    typedef struct {
        bit          v;
        logic [2:0]  c;
        bit          ordy;
        bit          ov;
        logic [11:0] data;
        bit          ir;
        logic [7:0]  cnt;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst_n, input bit v, input logic [2:0] c, input bit ordy);
        bit          can_take;
        logic [11:0] word;
        if (!rst_n) begin
            words_q.delete();
            cur_q.delete();
            m_cnt = 0;
            m_ovf = 1'b0;
        end else begin
            can_take = (words_q.size() < 2);
            if (words_q.size() > 0 && ordy) begin
                void'(words_q.pop_front());
                m_cnt++;
            end
            if (v) begin
                if (can_take) begin
                    cur_q.push_back(c);
                    if (cur_q.size() == 4) begin
                        word = 12'h000;
                        for (int k = 0; k < 4; k++) word = word | (12'(cur_q[k]) << (3 * k));
                        words_q.push_back(word);
                        cur_q.delete();
                    end
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic step(input bit v, input logic [2:0] c, input bit ordy);
        bus1.In_valid  = v;
        {bus1.C2, bus1.C1, bus1.C0} = c;
        bus1.Out_ready = ordy;
        @(posedge Clk);
        model_edge(Rst_n, v, c, ordy);
        #1;
        chk("in_ready", 32'(bus1.In_ready), 32'(words_q.size() < 2));
        chk("out_valid", 32'(bus1.Out_valid), 32'(words_q.size() > 0));
        if (words_q.size() > 0) chk("out_data", 32'(bus1.Out_data), 32'(words_q[0]));
        chk("word_cnt", 32'(bus1.Word_cnt), 32'(m_cnt % 256));
        chk("overflow", 32'(bus1.Overflow), 32'(m_ovf));
        chk("word_cnt_w2", 32'(bus2.Word_cnt), 32'(m_cnt % 4));
        chk("out_valid_w2", 32'(bus2.Out_valid), 32'(words_q.size() > 0));
    endtask

    initial begin
        vec_t        tbl[6];
        int          exp2[5];
        logic [2:0]  vals[4];
        logic [11:0] exp_word;

        Rst_n = 1'b0;
        bus1.In_valid = 1'b0;
        {bus1.C2, bus1.C1, bus1.C0} = 3'b000;
        bus1.Out_ready = 1'b0;

        // Reset with random inputs
        for (int i = 0; i < 2; i++) step(1'($urandom), 3'($urandom), 1'($urandom));
        chk("rst_out_valid", 32'(bus1.Out_valid), 32'd0);
        chk("rst_out_data", 32'(bus1.Out_data), 32'd0);
        chk("rst_word_cnt", 32'(bus1.Word_cnt), 32'd0);
        chk("rst_overflow", 32'(bus1.Overflow), 32'd0);
        chk("rst_in_ready", 32'(bus1.In_ready), 32'd1);
        Rst_n = 1'b1;

        // Basic pack: 1,2,3,4 -> 12'h8D1, valid for exactly one cycle
        tbl[0] = '{1'b1, 3'b001, 1'b1, 1'b0, 12'h000, 1'b1, 8'd0};
        tbl[1] = '{1'b1, 3'b010, 1'b1, 1'b0, 12'h000, 1'b1, 8'd0};
        tbl[2] = '{1'b1, 3'b011, 1'b1, 1'b0, 12'h000, 1'b1, 8'd0};
        tbl[3] = '{1'b1, 3'b100, 1'b1, 1'b1, 12'h8D1, 1'b1, 8'd0};
        tbl[4] = '{1'b0, 3'b111, 1'b1, 1'b0, 12'h000, 1'b1, 8'd1};
        tbl[5] = '{1'b0, 3'b000, 1'b1, 1'b0, 12'h000, 1'b1, 8'd1};
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].v, tbl[i].c, tbl[i].ordy);
            chk("tbl_out_valid", 32'(bus1.Out_valid), 32'(tbl[i].ov));
            if (tbl[i].ov) chk("tbl_out_data", 32'(bus1.Out_data), 32'(tbl[i].data));
            chk("tbl_in_ready", 32'(bus1.In_ready), 32'(tbl[i].ir));
            chk("tbl_word_cnt", 32'(bus1.Word_cnt), 32'(tbl[i].cnt));
        end

        // Backpressure: 9 results with Out_ready low, the 9th is dropped
        Rst_n = 1'b0;
        step(1'b0, 3'b000, 1'b0);
        Rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 3'(i + 1), 1'b0);
            if (i == 7) chk("bp_stall_in_ready", 32'(bus1.In_ready), 32'd0);
        end
        chk("bp_overflow", 32'(bus1.Overflow), 32'd1);
        chk("bp_word1", 32'(bus1.Out_data), 32'h8D1);
        step(1'b0, 3'b000, 1'b1);
        chk("bp_word2", 32'(bus1.Out_data), 32'h1F5);
        chk("bp_word2_valid", 32'(bus1.Out_valid), 32'd1);
        chk("bp_release_in_ready", 32'(bus1.In_ready), 32'd1);
        chk("bp_word_cnt", 32'(bus1.Word_cnt), 32'd1);
        step(1'b0, 3'b000, 1'b1);
        chk("bp_drain_valid", 32'(bus1.Out_valid), 32'd0);
        chk("bp_drain_cnt", 32'(bus1.Word_cnt), 32'd2);

        // Reset mid-word discards the partial word
        step(1'b1, 3'b101, 1'b1);
        step(1'b1, 3'b010, 1'b1);
        Rst_n = 1'b0;
        step(1'b1, 3'b110, 1'b1);
        Rst_n = 1'b1;
        chk("midrst_overflow", 32'(bus1.Overflow), 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 3'b111, 1'b1);
        chk("midrst_valid", 32'(bus1.Out_valid), 32'd1);
        chk("midrst_data", 32'(bus1.Out_data), 32'hFFF);

        // Two-bit counter wraps 1,2,3,0,1
        Rst_n = 1'b0;
        step(1'b0, 3'b000, 1'b1);
        Rst_n = 1'b1;
        exp2 = '{1, 2, 3, 0, 1};
        for (int w = 0; w < 5; w++) begin
            for (int i = 0; i < 4; i++) step(1'b1, 3'($urandom), 1'b1);
            step(1'b0, 3'($urandom), 1'b1);
            chk("wrap_cnt", 32'(bus2.Word_cnt), 32'(exp2[w]));
        end

        // Sparse input: idle gaps with random data lines
        for (int r = 0; r < 3; r++) begin
            exp_word = 12'h000;
            for (int i = 0; i < 4; i++) begin
                for (int g = 0; g < int'($urandom_range(0, 3)); g++) step(1'b0, 3'($urandom), 1'b1);
                vals[i] = 3'($urandom);
                exp_word = exp_word | (12'(vals[i]) << (3 * i));
                step(1'b1, vals[i], 1'b1);
            end
            chk("sparse_valid", 32'(bus1.Out_valid), 32'd1);
            chk("sparse_data", 32'(bus1.Out_data), 32'(exp_word));
        end

        // Random traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            Rst_n = ($urandom_range(0, 99) != 0);
            step(($urandom_range(0, 3) != 0), 3'($urandom), ($urandom_range(0, 2) != 0));
        end
        Rst_n = 1'b1;
        step(1'b0, 3'b000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
